seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_scan_driver_refresh_divider.sv | 26 ++
 rtl/seg7_scan_driver.sv | 98 +++++++++
 tb/tb_seg7_scan_driver.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared widths, blank pattern and digit glyphs for the seven-segment scan driver
package seg7_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // bit0 = seg a ... bit6 = seg g, 1 = lit
    localparam logic [SEG_W-1:0] SEG_DIGIT_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_DIGIT_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_DIGIT_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_DIGIT_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_DIGIT_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_DIGIT_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_DIGIT_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_DIGIT_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_DIGIT_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DIGIT_9 = 7'h6F;

    function automatic int IDX_W(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_refresh_divider.sv
// rtl/seg7_scan_driver_refresh_divider.sv - free-running dwell counter with wrap tick
module refresh_divider #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic                           tick,
    output logic [$clog2(REFRESH_DIV)-1:0] cnt
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment driver; GHOST_BLANK_EN adds blank cycles at each digit switch
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SEG_W-1:0]             din,
    input  logic                         wr_en,
    input  logic [IDX_W(NUM_DIGITS)-1:0] wr_addr,
    input  logic [NUM_DIGITS-1:0]        digit_en,
    output logic [SEG_W-1:0]             seg_out,
    output logic [NUM_DIGITS-1:0]        an_out,
    output logic                         frame_tick
);

    localparam int IW    = IDX_W(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_cfg
            $error("seg7_scan_driver: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES combination");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             addr_ok;
    logic             blank;
    logic [SEG_W-1:0] slot [NUM_DIGITS];
    logic [IW-1:0]    idx;
    logic             wrapped;

    refresh_divider #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_div (
        .clock(clock),
        .reset(reset),
        .tick (tick),
        .cnt  (cnt)
    );

    // With a power-of-two digit count every address is a real slot.
    generate
        if ((1 << IW) == NUM_DIGITS) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = (wr_addr < IW'(NUM_DIGITS));
        end
    endgenerate

`ifdef GHOST_BLANK_EN
    assign blank = (cnt < CNT_W'(BLANK_CYCLES));
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot[i] <= SEG_BLANK;
            end
        end else if (wr_en && addr_ok) begin
            slot[wr_addr] <= din;
        end
    end

    // wrapped suppresses frame_tick on the first frame after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx        <= '0;
            wrapped    <= 1'b0;
            seg_out    <= SEG_BLANK;
            an_out     <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (tick && idx == LAST_IDX) begin
                wrapped <= 1'b1;
            end
            frame_tick <= wrapped && (idx == '0) && (cnt == '0);
            if (blank) begin
                an_out  <= '0;
                seg_out <= SEG_BLANK;
            end else begin
                an_out  <= NUM_DIGITS'(1) << idx;
                seg_out <= digit_en[idx] ? slot[idx] : SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed vector bench for seg7_scan_driver
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] din;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] digit_en;
    logic [6:0] seg_out;
    logic [3:0] an_out;
    logic       frame_tick;

    logic [6:0] din5;
    logic       wr_en5;
    logic [2:0] wr_addr5;
    logic [4:0] digit_en5;
    logic [6:0] seg_out5;
    logic [4:0] an_out5;
    logic       frame_tick5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) u_dut (
        .clock(clock), .reset(reset), .din(din), .wr_en(wr_en), .wr_addr(wr_addr),
        .digit_en(digit_en), .seg_out(seg_out), .an_out(an_out), .frame_tick(frame_tick)
    );

    seg7_scan_driver #(.NUM_DIGITS(5), .REFRESH_DIV(4), .BLANK_CYCLES(1)) u_dut5 (
        .clock(clock), .reset(reset), .din(din5), .wr_en(wr_en5), .wr_addr(wr_addr5),
        .digit_en(digit_en5), .seg_out(seg_out5), .an_out(an_out5), .frame_tick(frame_tick5)
    );

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [6:0] wd;
        logic [3:0] den;
        logic [3:0] an;
        logic [6:0] seg;
        logic       ft;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic we, input logic [1:0] wa, input logic [6:0] wd,
                                input logic [3:0] den, input logic [3:0] an, input logic [6:0] seg,
                                input logic ft);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.den = den; v.an = an; v.seg = seg; v.ft = ft;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic [6:0] exp5 [5];
        bit         seen [5];
        bit         found;

        // edge-by-edge table; entry i drives edge i+1 after reset release
        add(0, 0, 7'h00, 4'hF, 4'b0001, 7'h00, 0);
        add(1, 0, SEG_DIGIT_0, 4'hF, 4'b0001, 7'h00, 0);
        add(1, 1, SEG_DIGIT_1, 4'hF, 4'b0001, 7'h3F, 0);
        add(1, 2, SEG_DIGIT_2, 4'hF, 4'b0001, 7'h3F, 0);
        add(1, 3, SEG_DIGIT_3, 4'hF, 4'b0010, 7'h06, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 7'h00, 4'hF, 4'b0010, 7'h06, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 7'h00, 4'hF, 4'b0100, 7'h5B, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 7'h00, 4'hF, 4'b1000, 7'h4F, 0);
        add(0, 0, 7'h00, 4'hF, 4'b0001, 7'h3F, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 7'h00, 4'hF, 4'b0001, 7'h3F, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 7'h00, 4'hB, 4'b0010, 7'h06, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 7'h00, 4'hB, 4'b0100, 7'h00, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 7'h00, 4'hB, 4'b1000, 7'h4F, 0);
        add(0, 0, 7'h00, 4'hF, 4'b0001, 7'h3F, 1);
        add(1, 0, 7'h7F, 4'hF, 4'b0001, 7'h3F, 0);
        add(0, 0, 7'h00, 4'hF, 4'b0001, 7'h7F, 0);
        add(0, 0, 7'h00, 4'hF, 4'b0001, 7'h7F, 0);

        // reset with a write pending: the write must be discarded
        reset = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; din = 7'h7F; digit_en = 4'hF;
        wr_en5 = 1'b0; wr_addr5 = 3'd0; din5 = 7'h00; digit_en5 = 5'h1F;
        step();
        step();
        check("reset_an", 8'(an_out), 8'h00);
        check("reset_seg", 8'(seg_out), 8'h00);
        check("reset_ft", 8'(frame_tick), 8'h00);

        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; din = vecs[i].wd; digit_en = vecs[i].den;
            step();
            e_an  = vecs[i].an;
            e_seg = vecs[i].seg;
`ifdef GHOST_BLANK_EN
            if ((i % 4) == 0) begin
                e_an  = 4'b0000;
                e_seg = 7'h00;
            end
`endif
            check($sformatf("vec%0d_an", i), 8'(an_out), 8'(e_an));
            check($sformatf("vec%0d_seg", i), 8'(seg_out), 8'(e_seg));
            check($sformatf("vec%0d_ft", i), 8'(frame_tick), 8'(vecs[i].ft));
        end

        // reset mid-scan while digit 2 is shown, with a write to slot 3 in flight
        wr_en = 1'b0; digit_en = 4'hF;
        found = 1'b0;
        for (int n = 0; n < 16 && !found; n++) begin
            step();
            if (an_out == 4'b0100) found = 1'b1;
        end
        check("reach_digit2", 8'(found), 8'h01);
        reset = 1'b1; wr_en = 1'b1; wr_addr = 2'd3; din = 7'h55;
        step();
        check("midrst_an", 8'(an_out), 8'h00);
        check("midrst_seg", 8'(seg_out), 8'h00);
        check("midrst_ft", 8'(frame_tick), 8'h00);
        reset = 1'b0; wr_en = 1'b0;
        step();
`ifdef GHOST_BLANK_EN
        check("restart_an", 8'(an_out), 8'h00);
`else
        check("restart_an", 8'(an_out), 8'h01);
`endif
        check("restart_seg", 8'(seg_out), 8'h00);
        check("restart_ft", 8'(frame_tick), 8'h00);
        for (int d = 0; d < 4; d++) begin
            if (d == 0) step(); else repeat (4) step();
            check($sformatf("cleared%0d_an", d), 8'(an_out), 8'(4'b0001 << d));
            check($sformatf("cleared%0d_seg", d), 8'(seg_out), 8'h00);
        end

        // five-digit instance: addresses 5..7 are out of range and must be ignored
        exp5[0] = SEG_DIGIT_1; exp5[1] = SEG_DIGIT_2; exp5[2] = SEG_DIGIT_3;
        exp5[3] = SEG_DIGIT_4; exp5[4] = SEG_DIGIT_5;
        for (int a = 0; a < 8; a++) begin
            wr_en5 = 1'b1; wr_addr5 = 3'(a);
            din5 = (a < 5) ? exp5[a] : 7'h7F;
            step();
        end
        wr_en5 = 1'b0;
        for (int d = 0; d < 5; d++) seen[d] = 1'b0;
        for (int n = 0; n < 24; n++) begin
            step();
            for (int d = 0; d < 5; d++) begin
                if (an_out5 == 5'(5'b00001 << d)) begin
                    seen[d] = 1'b1;
                    check($sformatf("d5_seg%0d", d), 8'(seg_out5), 8'(exp5[d]));
                end
            end
        end
        for (int d = 0; d < 5; d++) check($sformatf("d5_seen%0d", d), 8'(seen[d]), 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
